avmm_cmd_master: RTL and testbench
==================================

// Module: avmm_cmd_master
// PURPOSE
//  Avalon-MM initiator: turns single-beat commands from a valid/ready stream into Avalon-MM
//  read/write transfers and returns one response per command on a valid/ready stream.
//  Lets fabric logic drive memory-mapped peripherals (LED/switch register slaves etc.) with no HPS.
//  One transfer outstanding at a time; honours waitrequest and readdatavalid.
// PARAMETERS
//  ADDR_W          8     width of cmd_address / avm_address (word address)
//  TIMEOUT_CYCLES  1024  cycles allowed per transfer before error (only with timeout macro)
// PORTS
//  clk                input   1       clock
//  reset              input   1       synchronous, active-high reset
//  cmd_valid          input   1       command present
//  cmd_ready          output  1       command accepted when valid&&ready
//  cmd_write          input   1       1=write, 0=read
//  cmd_address        input   ADDR_W  target word address
//  cmd_writedata      input   32      write data
//  cmd_byteenable     input   4       byte lanes
//  rsp_valid          output  1       response present
//  rsp_ready          input   1       response consumed when valid&&ready
//  rsp_readdata       output  32      read data (0 for writes)
//  rsp_error          output  1       transfer timed out
//  avm_address        output  ADDR_W  Avalon address
//  avm_read           output  1       Avalon read strobe
//  avm_write          output  1       Avalon write strobe
//  avm_writedata      output  32      Avalon write data
//  avm_byteenable     output  4       Avalon byte enables
//  avm_waitrequest    input   1       slave stall
//  avm_readdata       input   32      slave read data
//  avm_readdatavalid  input   1       slave read data qualifier
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=0 during reset, 1 the cycle after; rsp_valid=0; rsp_readdata=0;
//   rsp_error=0; avm_read=avm_write=0; avm_address/writedata/byteenable=0. Reset aborts any transfer.
//  FSM: IDLE -> (cmd fire) WR_REQ or RD_REQ; cmd fields registered on fire into avm_* regs.
//  cmd_ready=1 only in IDLE (registered); no command accepted while a response is pending.
//  WR_REQ: avm_write=1 from the cycle after fire; held with stable address/data/byteenable
//   while avm_waitrequest=1; on cycle with avm_waitrequest=0 drop avm_write next cycle,
//   load rsp_readdata=0, rsp_error=0 -> RESP.
//  RD_REQ: avm_read=1 held while avm_waitrequest=1; on accept drop avm_read -> RD_WAIT.
//   readdatavalid in the accept cycle itself (zero-latency slave) is captured -> RESP directly.
//  RD_WAIT: on avm_readdatavalid capture avm_readdata into rsp_readdata -> RESP.
//  avm_readdatavalid outside RD_REQ-accept/RD_WAIT is ignored.
//  RESP: rsp_valid=1, data stable until rsp_ready; on fire -> IDLE (cmd_ready=1 next cycle).
//  Min latency cmd fire -> rsp_valid: write 2 cycles, read 2 + slave read latency.
//  Max throughput: one command per 3 cycles (IDLE, REQ, RESP) with zero-wait slave.
// CONFIGURATION
//  AVMM_CMD_MASTER_TIMEOUT_EN defined: cycle counter cleared on cmd fire, increments in
//   WR_REQ/RD_REQ/RD_WAIT; on reaching TIMEOUT_CYCLES-1 drop avm_read/avm_write, load
//   rsp_readdata=32'h0, rsp_error=1 -> RESP. Timeout wins over same-cycle accept/readdatavalid.
//  Not defined: no counter; transfers wait indefinitely; rsp_error constant 0.
// STRUCTURE
//  avmm_cmd_master_pkg: state enum (IDLE, WR_REQ, RD_REQ, RD_WAIT, RESP), response struct
//   {readdata, error}, localparam DATA_W=32, BE_W=4.
//  One sub-module avmm_timeout_ctr (clear/enable/expired), instantiated only under macro.
// TESTING
//  Write addr 0x00 data 0x000000A5 be 0xF, waitrequest=0 -> one-cycle avm_write, rsp {0,0}.
//  Read addr 0x00, slave returns 0x0000000C after 1 cycle -> rsp_readdata=0x0000000C, err=0.
//  Write with waitrequest high 5 cycles -> avm_write/address/data stable 6 cycles, one rsp.
//  rsp_ready held low 4 cycles -> rsp stable, cmd_ready=0, second cmd not accepted.
//  Macro on, TIMEOUT_CYCLES=16, waitrequest stuck 1 -> strobe drops, rsp_error=1, data 0.
//  Reset asserted in RD_WAIT -> all outputs reset values next cycle; later readdatavalid ignored.

Source files
------------

// File: rtl/avmm_cmd_master_pkg.sv
// Shared types for the Avalon-MM command master.
// States, response bundle and bus widths.
package avmm_cmd_master_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t WR_REQ  = 3'd1;
  localparam state_t RD_REQ  = 3'd2;
  localparam state_t RD_WAIT = 3'd3;
  localparam state_t RESP    = 3'd4;

  typedef struct packed {
    logic [DATA_W-1:0] readdata;
    logic              error;
  } rsp_t;

endpackage

// File: rtl/avmm_cmd_master_if.sv
// Command, response and Avalon-MM signal bundle.
// master = the command master block, slave = its environment.
interface avmm_cmd_master_if #(
  parameter int ADDR_W = 8
);
  import avmm_cmd_master_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_writedata;
  logic [BE_W-1:0]   cmd_byteenable;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_readdata;
  logic              rsp_error;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [BE_W-1:0]   avm_byteenable;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    input  cmd_valid, cmd_write, cmd_address,
    input  cmd_writedata, cmd_byteenable,
    output cmd_ready,
    output rsp_valid, rsp_readdata, rsp_error,
    input  rsp_ready,
    output avm_address, avm_read, avm_write,
    output avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address,
    output cmd_writedata, cmd_byteenable,
    input  cmd_ready,
    input  rsp_valid, rsp_readdata, rsp_error,
    output rsp_ready,
    input  avm_address, avm_read, avm_write,
    input  avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/avmm_cmd_master_timeout_ctr.sv
// Per-transfer cycle counter; expired at CYCLES-1.
// Used only when AVMM_CMD_MASTER_TIMEOUT_EN is defined.
module avmm_timeout_ctr #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/avmm_cmd_master.sv
// Avalon-MM initiator: one command in, one transfer, one response.
// Optional AVMM_CMD_MASTER_TIMEOUT_EN adds a per-transfer timeout.
module avmm_cmd_master
  import avmm_cmd_master_pkg::*;
#(
  parameter int ADDR_W = 8
`ifdef AVMM_CMD_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input logic           clk,
  input logic           reset,
  avmm_cmd_master_if.master bus
);

  state_t            state;
  logic              cmd_rdy;
  logic              rsp_vld;
  rsp_t              rsp_q;
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              cmd_fire;
  logic              tmo;

  assign cmd_fire = bus.cmd_valid && cmd_rdy;

`ifdef AVMM_CMD_MASTER_TIMEOUT_EN
  logic busy;

  assign busy = (state == WR_REQ) ||
                (state == RD_REQ) ||
                (state == RD_WAIT);

  avmm_timeout_ctr #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clear   (cmd_fire),
    .enable  (busy),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  // Timeout is tested first so it wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cmd_rdy <= 1'b0;
      rsp_vld <= 1'b0;
      rsp_q   <= '0;
      rd      <= 1'b0;
      wr      <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      be      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cmd_rdy <= 1'b1;
          if (cmd_fire) begin
            cmd_rdy <= 1'b0;
            addr    <= bus.cmd_address;
            wdata   <= bus.cmd_writedata;
            be      <= bus.cmd_byteenable;
            if (bus.cmd_write) begin
              wr    <= 1'b1;
              state <= WR_REQ;
            end else begin
              rd    <= 1'b1;
              state <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (tmo) begin
            wr      <= 1'b0;
            rsp_q   <= '{readdata: '0, error: 1'b1};
            rsp_vld <= 1'b1;
            state   <= RESP;
          end else if (!bus.avm_waitrequest) begin
            wr      <= 1'b0;
            rsp_q   <= '{readdata: '0, error: 1'b0};
            rsp_vld <= 1'b1;
            state   <= RESP;
          end
        end
        RD_REQ: begin
          if (tmo) begin
            rd      <= 1'b0;
            rsp_q   <= '{readdata: '0, error: 1'b1};
            rsp_vld <= 1'b1;
            state   <= RESP;
          end else if (!bus.avm_waitrequest) begin
            rd <= 1'b0;
            if (bus.avm_readdatavalid) begin
              rsp_q   <= '{readdata: bus.avm_readdata,
                           error: 1'b0};
              rsp_vld <= 1'b1;
              state   <= RESP;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (tmo) begin
            rsp_q   <= '{readdata: '0, error: 1'b1};
            rsp_vld <= 1'b1;
            state   <= RESP;
          end else if (bus.avm_readdatavalid) begin
            rsp_q   <= '{readdata: bus.avm_readdata,
                         error: 1'b0};
            rsp_vld <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_vld <= 1'b0;
            cmd_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          cmd_rdy <= 1'b0;
          rsp_vld <= 1'b0;
          rd      <= 1'b0;
          wr      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready      = cmd_rdy;
  assign bus.rsp_valid      = rsp_vld;
  assign bus.rsp_readdata   = rsp_q.readdata;
  assign bus.rsp_error      = rsp_q.error;
  assign bus.avm_address    = addr;
  assign bus.avm_read       = rd;
  assign bus.avm_write      = wr;
  assign bus.avm_writedata  = wdata;
  assign bus.avm_byteenable = be;

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Directed bench for avmm_cmd_master.
// Define AVMM_CMD_MASTER_TIMEOUT_EN to exercise the timeout path.
module tb_avmm_cmd_master;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  avmm_cmd_master_if #(.ADDR_W(8)) bus ();

`ifdef AVMM_CMD_MASTER_TIMEOUT_EN
  avmm_cmd_master #(
    .ADDR_W         (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
`else
  avmm_cmd_master #(
    .ADDR_W (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_cmd(input logic w,
                          input logic [7:0] a,
                          input logic [31:0] d,
                          input logic [3:0] b);
    bit ok;
    bus.cmd_valid      = 1'b1;
    bus.cmd_write      = w;
    bus.cmd_address    = a;
    bus.cmd_writedata  = d;
    bus.cmd_byteenable = b;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b need 1",
               bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.avm_read !== 1'b0 || bus.avm_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: rdy=%b vld=%b rd=%b wr=%b need 0",
               bus.cmd_ready, bus.rsp_valid,
               bus.avm_read, bus.avm_write);
    end
    checks++;
    if (bus.avm_address !== 8'h0 || bus.avm_writedata !== 32'h0 ||
        bus.avm_byteenable !== 4'h0 || bus.rsp_readdata !== 32'h0 ||
        bus.rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: a=%h d=%h be=%h rd=%h e=%b need 0",
               bus.avm_address, bus.avm_writedata,
               bus.avm_byteenable, bus.rsp_readdata, bus.rsp_error);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b need 1",
               bus.cmd_ready);
    end
  endtask

  task automatic test_write;
    bus.avm_waitrequest = 1'b0;
    send_cmd(1'b1, 8'h00, 32'h0000_00A5, 4'hF);
    checks++;
    if (bus.avm_write !== 1'b1 || bus.avm_address !== 8'h00 ||
        bus.avm_writedata !== 32'h0000_00A5 ||
        bus.avm_byteenable !== 4'hF || bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_strobe: wr=%b a=%h d=%h be=%h rdy=%b",
               bus.avm_write, bus.avm_address, bus.avm_writedata,
               bus.avm_byteenable, bus.cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.avm_write !== 1'b0 || bus.rsp_valid !== 1'b1 ||
        bus.rsp_readdata !== 32'h0 || bus.rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsp: wr=%b vld=%b rd=%h e=%b need 0,1,0,0",
               bus.avm_write, bus.rsp_valid,
               bus.rsp_readdata, bus.rsp_error);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_done: vld=%b rdy=%b need 0,1",
               bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_read;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_stray: vld=%b rdy=%b need 0,1",
               bus.rsp_valid, bus.cmd_ready);
    end
    send_cmd(1'b0, 8'h00, 32'h0, 4'hF);
    checks++;
    if (bus.avm_read !== 1'b1 || bus.avm_write !== 1'b0) begin
      errors++;
      $display("FAIL rd_strobe: rd=%b wr=%b need 1,0",
               bus.avm_read, bus.avm_write);
    end
    @(negedge clk);
    checks++;
    if (bus.avm_read !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_wait: rd=%b vld=%b need 0,0",
               bus.avm_read, bus.rsp_valid);
    end
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'h0000_000C;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_readdata !== 32'h0000_000C ||
        bus.rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL rd_rsp: vld=%b rd=%h e=%b need 1,0000000c,0",
               bus.rsp_valid, bus.rsp_readdata, bus.rsp_error);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    send_cmd(1'b0, 8'h03, 32'h0, 4'hF);
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'h1234_5678;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_readdata !== 32'h1234_5678 ||
        bus.avm_read !== 1'b0) begin
      errors++;
      $display("FAIL rd_zero_lat: vld=%b rd=%h str=%b need 1,12345678,0",
               bus.rsp_valid, bus.rsp_readdata, bus.avm_read);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_waitrequest;
    int bad;
    bus.avm_waitrequest = 1'b1;
    send_cmd(1'b1, 8'h5A, 32'h1122_3344, 4'h3);
    bad = 0;
    for (int i = 1; i <= 6; i++) begin
      if (bus.avm_write !== 1'b1 || bus.avm_address !== 8'h5A ||
          bus.avm_writedata !== 32'h1122_3344 ||
          bus.avm_byteenable !== 4'h3 || bus.rsp_valid !== 1'b0)
        bad++;
      if (i == 6) bus.avm_waitrequest = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_stable: unstable cycles=%0d need 0", bad);
    end
    checks++;
    if (bus.avm_write !== 1'b0 || bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_rsp: wr=%b vld=%b need 0,1",
               bus.avm_write, bus.rsp_valid);
    end
    bus.rsp_ready = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) bad++;
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_one_rsp: extra rsp cycles=%0d need 0", bad);
    end
  endtask

  task automatic test_backpressure;
    int bad;
    send_cmd(1'b0, 8'h10, 32'h0, 4'hF);
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'hCAFE_F00D;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    bus.cmd_valid         = 1'b1;
    bus.cmd_write         = 1'b1;
    bus.cmd_address       = 8'h07;
    bus.cmd_writedata     = 32'h0000_0077;
    bus.cmd_byteenable    = 4'h1;
    bad = 0;
    repeat (4) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_readdata !== 32'hCAFE_F00D ||
          bus.cmd_ready !== 1'b0 || bus.avm_write !== 1'b0 ||
          bus.avm_read !== 1'b0)
        bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: bad cycles=%0d need 0", bad);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        bus.avm_write !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b wr=%b need 0,1,0",
               bus.rsp_valid, bus.cmd_ready, bus.avm_write);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.avm_write !== 1'b1 || bus.avm_address !== 8'h07 ||
        bus.avm_writedata !== 32'h0000_0077) begin
      errors++;
      $display("FAIL bp_second: wr=%b a=%h d=%h need 1,07,00000077",
               bus.avm_write, bus.avm_address, bus.avm_writedata);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    bus.avm_waitrequest = 1'b1;
    send_cmd(1'b0, 8'h22, 32'h0, 4'hF);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      if (bus.avm_read === 1'b1) n++;
      @(negedge clk);
    end
`ifdef AVMM_CMD_MASTER_TIMEOUT_EN
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL tmo_len: strobe cycles=%0d need 16", n);
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 ||
        bus.rsp_readdata !== 32'h0 || bus.avm_read !== 1'b0) begin
      errors++;
      $display("FAIL tmo_rsp: vld=%b e=%b rd=%h str=%b need 1,1,0,0",
               bus.rsp_valid, bus.rsp_error,
               bus.rsp_readdata, bus.avm_read);
    end
    bus.avm_waitrequest = 1'b0;
`else
    checks++;
    if (n != 40 || bus.rsp_valid !== 1'b0 || bus.avm_read !== 1'b1) begin
      errors++;
      $display("FAIL no_tmo: cycles=%0d vld=%b str=%b need 40,0,1",
               n, bus.rsp_valid, bus.avm_read);
    end
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'h0000_0055;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0 ||
        bus.rsp_readdata !== 32'h0000_0055) begin
      errors++;
      $display("FAIL no_tmo_rsp: vld=%b e=%b rd=%h need 1,0,00000055",
               bus.rsp_valid, bus.rsp_error, bus.rsp_readdata);
    end
`endif
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_abort;
    int bad;
    send_cmd(1'b0, 8'h44, 32'h0, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.avm_read !== 1'b0 ||
        bus.rsp_valid !== 1'b0 || bus.avm_address !== 8'h0) begin
      errors++;
      $display("FAIL abort_reset: rdy=%b rd=%b vld=%b a=%h need 0",
               bus.cmd_ready, bus.avm_read,
               bus.rsp_valid, bus.avm_address);
    end
    reset = 1'b0;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'h0000_0099;
    @(negedge clk);
    bus.avm_readdatavalid = 1'b0;
    bad = 0;
    repeat (3) begin
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_ignore: bad cycles=%0d need 0", bad);
    end
  endtask

  initial begin
    checks                = 0;
    errors                = 0;
    reset                 = 1'b1;
    bus.cmd_valid         = 1'b0;
    bus.cmd_write         = 1'b0;
    bus.cmd_address       = '0;
    bus.cmd_writedata     = '0;
    bus.cmd_byteenable    = '0;
    bus.rsp_ready         = 1'b0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdata      = '0;
    bus.avm_readdatavalid = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_waitrequest();
    test_backpressure();
    test_timeout();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
